icache_controller: RTL and testbench
====================================

# icache_controller

Sequencing controller for the direct-mapped instruction-cache set. It sits between the fetch stage and the cache-set datapath. It answers fetch requests on a hit, refills a whole line from instruction memory on a miss, and sweeps all entries invalid after reset or on an explicit flush. The set has no flag reset of its own, so this block is the only source of cache-content initialisation.

## Interface
- CACHE_BLOCKS, 4: words per line; legal values 2, 4, 8. BLOCK_WIDTH = $clog2(CACHE_BLOCKS).
- CACHE_ELEMENTS, 128: lines in the set. INDEX_WIDTH = $clog2(CACHE_ELEMENTS).
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset; synchronous, active-low.
- i_addr  in  InstAddr  fetch word address; must stay stable while i_rd is high and o_valid is low.
- i_rd  in  1  fetch request.
- i_flush  in  1  invalidate-all request; one-cycle pulse.
- o_inst  out  Inst  fetched instruction; valid only when o_valid is high.
- o_valid  out  1  fetch completed this cycle.
- o_busy  out  1  controller is not in IDLE.
- o_set_addr  out  InstAddr  address to the set.
- o_set_wr  out  1  set write strobe.
- o_set_cl  out  1  set invalidate strobe.
- o_set_inst  out  Inst  write data to the set.
- i_set_inst  in  Inst  set read data.
- i_set_hit  in  1  set hit.
- o_mem_addr  out  InstAddr  memory read address.
- o_mem_rd  out  1  memory read request.
- i_mem_inst  in  Inst  memory read data.
- i_mem_ack  in  1  memory data valid; may assert in the same cycle as o_mem_rd.
- o_hits  out  32  hit counter.
- o_misses  out  32  miss counter.

## Operation
- States: FLUSH, IDLE, FILL.
- **Reset.** While i_reset is low: o_valid, o_set_wr, o_set_cl and o_mem_rd are 0; o_busy is 1. All counters and the pending flag clear, and the state is set to FLUSH with the flush counter at 0. Reset mid-FILL abandons the burst with no further memory requests; memory must tolerate the abandoned request.
- **FLUSH.**
  - o_set_cl=1 and o_set_addr={tag 0, flush_cnt, block 0}.
  - flush_cnt (INDEX_WIDTH bits) increments each cycle.
  - After the cycle with flush_cnt=CACHE_ELEMENTS-1, go to IDLE.
- **IDLE.**
  - o_set_addr=i_addr.
  - If i_flush (or the pending flag) is set, go to FLUSH. Flush has priority over i_rd, and no o_valid is issued that cycle.
  - Else if i_rd and i_set_hit: o_valid=1 and o_inst=i_set_inst, combinationally in the same cycle.
  - Else if i_rd and no hit: latch line_base={i_addr tag+index, block 0}, clear fill_cnt, go to FILL.
- **FILL.**
  - o_mem_rd=1 and o_mem_addr=line_base+fill_cnt.
  - On i_mem_ack: o_set_wr=1, o_set_addr=o_mem_addr, o_set_inst=i_mem_inst, and fill_cnt (BLOCK_WIDTH bits) increments.
  - On the ack for fill_cnt=CACHE_BLOCKS-1, go to IDLE. The request then replays and hits.
  - i_flush during FILL sets the pending flag; the flush runs after the fill completes.
  - o_valid is never asserted in FILL.
- o_set_wr and o_set_cl are never asserted together.
- The line is marked valid on its first written word, so the fetch side is held off (o_busy) until the whole line is written.

## Timing
- Hit: 0-cycle latency; o_valid is high in the request cycle.
- Miss with zero-wait memory: detect at cycle T, fill writes at T+1..T+CACHE_BLOCKS, hit at T+CACHE_BLOCKS+1.
- Each wait cycle without i_mem_ack adds one cycle to the miss.
- Flush: CACHE_ELEMENTS cycles with o_busy=1, then IDLE.
- First reset release: 128 cycles (default) before the first possible hit.
- At most one memory word is accepted per cycle.

## Configuration
- ICACHE_STATS_EN defined:
  - o_hits increments on each o_valid.
  - o_misses increments on each IDLE→FILL transition.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- ICACHE_STATS_EN undefined: o_hits and o_misses are constant 0 and no counter logic is built. Ports remain present.

## Structure
- Types package holds InstAddr and Inst (existing) plus the new ICacheCtrlState enum (FLUSH, IDLE, FILL).
- BLOCK_WIDTH and INDEX_WIDTH are local parameters derived from the module parameters.
- One sub-module, icache_stats, holds both counters and is instantiated only under ICACHE_STATS_EN.
- The set itself is instantiated beside this block by the cache top, not inside it.

## Test plan
- Reset release: o_set_cl is high for exactly 128 consecutive cycles, with addresses covering every index, then o_busy=0.
- Cold fetch of 0x40, zero-wait memory: o_mem_addr runs 0x40..0x43 on consecutive cycles, o_set_wr is asserted 4×, and o_valid is high 6 cycles after the request with data from mem[0x40].
- Fetch 0x41 after that fill: o_valid in the same cycle with no memory traffic; with ICACHE_STATS_EN, o_hits=2 and o_misses=1.
- Miss with i_mem_ack delayed 3 cycles per word: miss penalty is 4×4+2 cycles, and o_mem_addr is held stable during each wait.
- i_flush pulsed during FILL of 0x80: the fill completes, 128 flush cycles follow, and a refetch of 0x80 misses.
- i_reset low on the third fill word of 0x100: o_mem_rd drops, a full flush follows, and a fetch of 0x101 then misses (no stale partial line).

Source files
------------

// File: rtl/icache_controller_pkg.sv
// icache_controller_pkg: address/instruction types and controller state for the I-cache.
package icache_controller_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int INST_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] InstAddr;
    typedef logic [INST_WIDTH-1:0] Inst;
    typedef enum logic [1:0] {FLUSH, IDLE, FILL} ICacheCtrlState;
endpackage

// File: rtl/icache_stats.sv
// icache_stats: free-running hit and miss counters, wrapping modulo 2^32.
module icache_stats (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        hit,
    input  logic        miss,
    output logic [31:0] hits,
    output logic [31:0] misses
);
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            hits <= '0;
            misses <= '0;
        end else begin
            hits <= hits + 32'(hit);
            misses <= misses + 32'(miss);
        end
    end
endmodule

// File: rtl/icache_controller.sv
// icache_controller: hit/refill/flush sequencer for the direct-mapped I-cache set.
// Define ICACHE_STATS_EN to build the hit/miss counters behind o_hits/o_misses.
module icache_controller
    import icache_controller_pkg::*;
#(
    parameter int CACHE_BLOCKS = 4,
    parameter int CACHE_ELEMENTS = 128
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  InstAddr     i_addr,
    input  logic        i_rd,
    input  logic        i_flush,
    output Inst         o_inst,
    output logic        o_valid,
    output logic        o_busy,
    output InstAddr     o_set_addr,
    output logic        o_set_wr,
    output logic        o_set_cl,
    output Inst         o_set_inst,
    input  Inst         i_set_inst,
    input  logic        i_set_hit,
    output InstAddr     o_mem_addr,
    output logic        o_mem_rd,
    input  Inst         i_mem_inst,
    input  logic        i_mem_ack,
    output logic [31:0] o_hits,
    output logic [31:0] o_misses
);
    localparam int BLOCK_WIDTH = $clog2(CACHE_BLOCKS);
    localparam int INDEX_WIDTH = $clog2(CACHE_ELEMENTS);
    localparam int LINE_WIDTH = ADDR_WIDTH - BLOCK_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(CACHE_ELEMENTS - 1);
    localparam logic [BLOCK_WIDTH-1:0] LAST_BLOCK = BLOCK_WIDTH'(CACHE_BLOCKS - 1);

    ICacheCtrlState state, next_state;
    logic [INDEX_WIDTH-1:0] flush_cnt;
    logic [BLOCK_WIDTH-1:0] fill_cnt;
    logic [LINE_WIDTH-1:0] line_base;
    InstAddr mem_addr;
    logic pending, flush_req, miss;

    assign flush_req = i_flush | pending;
    assign miss = i_reset && state == IDLE && !flush_req && i_rd && !i_set_hit;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= FLUSH;
            flush_cnt <= '0;
            fill_cnt <= '0;
            line_base <= '0;
            pending <= 1'b0;
        end else begin
            state <= next_state;
            flush_cnt <= state == FLUSH ? flush_cnt + 1'b1 : '0;
            fill_cnt <= state == FILL ? fill_cnt + BLOCK_WIDTH'(i_mem_ack) : '0;
            // a flush arriving mid-burst is deferred until the line is complete
            pending <= state == FILL && (pending || i_flush);
            if (state == IDLE) line_base <= i_addr[ADDR_WIDTH-1:BLOCK_WIDTH];
        end
    end

    always_comb begin
        next_state = state == FLUSH ? (flush_cnt == LAST_INDEX ? IDLE : FLUSH)
                   : state == IDLE  ? (flush_req ? FLUSH : miss ? FILL : IDLE)
                   : (i_mem_ack && fill_cnt == LAST_BLOCK ? IDLE : FILL);
    end

    always_comb begin
        mem_addr = {line_base, fill_cnt};
        o_mem_addr = mem_addr;
        o_mem_rd = i_reset && state == FILL;
        o_set_wr = o_mem_rd && i_mem_ack;
        o_set_cl = i_reset && state == FLUSH;
        o_set_inst = i_mem_inst;
        o_set_addr = state == FLUSH ? InstAddr'({flush_cnt, {BLOCK_WIDTH{1'b0}}})
                   : state == FILL  ? mem_addr : i_addr;
        o_valid = i_reset && state == IDLE && !flush_req && i_rd && i_set_hit;
        o_inst = i_set_inst;
        o_busy = !i_reset || state != IDLE;
    end

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .hit(o_valid),
        .miss(miss),
        .hits(o_hits),
        .misses(o_misses)
    );
`else
    assign o_hits = '0;
    assign o_misses = '0;
`endif
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed bench with set/memory models and an expected-instruction scoreboard.
module tb_icache_controller;
    import icache_controller_pkg::*;

    logic i_clock = 1'b0, i_reset = 1'b0, i_rd = 1'b0, i_flush = 1'b0;
    InstAddr i_addr = '0;
    Inst o_inst, o_set_inst, i_set_inst, i_mem_inst;
    logic o_valid, o_busy, o_set_wr, o_set_cl, i_set_hit, o_mem_rd, mem_ack;
    InstAddr o_set_addr, o_mem_addr;
    logic [31:0] o_hits, o_misses;

    int compared = 0, mismatched = 0;
    int mem_wait = 0, wcnt = 0;
    Inst exp_q[$];

    always #5 i_clock = ~i_clock;

    icache_controller dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_addr(i_addr), .i_rd(i_rd), .i_flush(i_flush),
        .o_inst(o_inst), .o_valid(o_valid), .o_busy(o_busy),
        .o_set_addr(o_set_addr), .o_set_wr(o_set_wr), .o_set_cl(o_set_cl), .o_set_inst(o_set_inst),
        .i_set_inst(i_set_inst), .i_set_hit(i_set_hit),
        .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_inst(i_mem_inst), .i_mem_ack(mem_ack),
        .o_hits(o_hits), .o_misses(o_misses)
    );

    function automatic Inst mem_word(InstAddr a);
        return {~a, a};
    endfunction

    // set model: no flag reset, powers up claiming every line valid with tag 0
    logic set_valid [128] = '{default: 1'b1};
    logic [6:0] set_tag [128] = '{default: 7'd0};
    Inst set_data [128][4] = '{default: '{default: 32'hDEAD_BEEF}};
    logic [6:0] s_idx, s_tag;
    logic [1:0] s_blk;
    assign s_idx = o_set_addr[8:2];
    assign s_tag = o_set_addr[15:9];
    assign s_blk = o_set_addr[1:0];
    assign i_set_hit = set_valid[s_idx] && set_tag[s_idx] == s_tag;
    assign i_set_inst = set_data[s_idx][s_blk];
    always @(posedge i_clock) begin
        if (o_set_cl) set_valid[s_idx] <= 1'b0;
        if (o_set_wr) begin
            set_valid[s_idx] <= 1'b1;
            set_tag[s_idx] <= s_tag;
            set_data[s_idx][s_blk] <= o_set_inst;
        end
    end

    assign mem_ack = o_mem_rd && wcnt == mem_wait;
    assign i_mem_inst = mem_word(o_mem_addr);
    always @(posedge i_clock) wcnt <= (o_mem_rd && !mem_ack) ? wcnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clock) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(o_valid), 32'd0);
            else check("inst", o_inst, exp_q.pop_front());
        end
    end

    task automatic flush_check(input string tag);
        int n = 0, errs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clock);
            if (o_set_cl !== 1'b1) break;
            if (o_set_addr !== InstAddr'(n * 4)) errs++;
            n++;
        end
        check({tag, "_cl_cycles"}, 32'(n), 32'd128);
        check({tag, "_cl_addr"}, 32'(errs), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic fetch(input string tag, input InstAddr a, input int wt, input int flush_at,
                         input int exp_lat, input int exp_words, input int exp_cl);
        int lat = 0, k = 0, nwr = 0, ncl = 0, errs = 0;
        InstAddr line = a & ~InstAddr'(3);
        @(posedge i_clock); #1;
        i_addr = a;
        i_rd = 1'b1;
        mem_wait = wt;
        exp_q.push_back(mem_word(a));
        for (int c = 1; c <= 400; c++) begin
            @(negedge i_clock);
            if (o_set_cl) ncl++;
            if (o_set_wr) nwr++;
            if (o_set_wr && !o_mem_rd) errs++;
            if (o_mem_rd) begin
                if (o_mem_addr !== InstAddr'(int'(line) + k % 4)) errs++;
                if (mem_ack) begin
                    if (o_set_wr !== 1'b1 || o_set_addr !== o_mem_addr || o_set_inst !== mem_word(o_mem_addr)) errs++;
                    k++;
                end
            end
            if (o_valid) begin
                lat = c;
                break;
            end
            i_flush = (c == flush_at);
        end
        i_flush = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_set_wr"}, 32'(nwr), 32'(exp_words));
        check({tag, "_set_cl"}, 32'(ncl), 32'(exp_cl));
        check({tag, "_mem_seq"}, 32'(errs), 32'd0);
        @(posedge i_clock); #1;
        i_rd = 1'b0;
    endtask

    initial begin
        i_addr = 16'h0040;
        i_rd = 1'b1;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_set_cl", 32'(o_set_cl), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        check("rst_set_wr", 32'(o_set_wr), 32'd0);
        check("rst_hits", o_hits, 32'd0);
        @(posedge i_clock); #1;
        i_rd = 1'b0;
        i_reset = 1'b1;
        flush_check("boot");
        fetch("cold", 16'h0040, 0, 0, 6, 4, 0);
        fetch("hit", 16'h0041, 0, 0, 1, 0, 0);
`ifdef ICACHE_STATS_EN
        check("hits_after_hit", o_hits, 32'd2);
        check("misses_after_hit", o_misses, 32'd1);
`else
        check("hits_const", o_hits, 32'd0);
        check("misses_const", o_misses, 32'd0);
`endif
        fetch("slow", 16'h0200, 3, 0, 18, 4, 0);
        fetch("flush_in_fill", 16'h0080, 0, 3, 140, 8, 128);
        fetch("rehit", 16'h0080, 0, 0, 1, 0, 0);
        @(posedge i_clock); #1;
        i_addr = 16'h0100;
        i_rd = 1'b1;
        mem_wait = 0;
        repeat (4) @(negedge i_clock);
        check("abort_word2_rd", 32'(o_mem_rd), 32'd1);
        check("abort_word2_addr", 32'(o_mem_addr), 32'h0102);
        i_reset = 1'b0;
        #1;
        check("abort_mem_rd", 32'(o_mem_rd), 32'd0);
        check("abort_set_wr", 32'(o_set_wr), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd1);
        @(posedge i_clock); #1;
        i_rd = 1'b0;
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        flush_check("rst");
        fetch("after_abort", 16'h0101, 0, 0, 6, 4, 0);
`ifdef ICACHE_STATS_EN
        check("hits_after_rst", o_hits, 32'd1);
        check("misses_after_rst", o_misses, 32'd1);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
